// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 register IDs, widths and ID helpers
package y86_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 15;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RAX   = 4'h0;
  localparam reg_id_t RCX   = 4'h1;
  localparam reg_id_t RDX   = 4'h2;
  localparam reg_id_t RBX   = 4'h3;
  localparam reg_id_t RSP   = 4'h4;
  localparam reg_id_t RBP   = 4'h5;
  localparam reg_id_t RSI   = 4'h6;
  localparam reg_id_t RDI   = 4'h7;
  localparam reg_id_t R8    = 4'h8;
  localparam reg_id_t R9    = 4'h9;
  localparam reg_id_t R10   = 4'hA;
  localparam reg_id_t R11   = 4'hB;
  localparam reg_id_t R12   = 4'hC;
  localparam reg_id_t R13   = 4'hD;
  localparam reg_id_t R14   = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  // 0xF is the "no register" encoding on every port
  function automatic logic is_real_id(input reg_id_t id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/y86_reg_read_mux.sv
// rtl/y86_reg_read_mux.sv - register select returning zero for RNONE or unmapped IDs
module y86_reg_read_mux
  import y86_pkg::*;
#(
  parameter int W     = y86_pkg::DATA_W,
  parameter int NREGS = y86_pkg::NUM_REGS
) (
  input  logic [W-1:0] regs [NREGS],
  input  reg_id_t      sel,
  output logic [W-1:0] val
);

  always_comb begin
    val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel == reg_id_t'(i)) begin
        val = regs[i];
      end
    end
  end

endmodule

// File: rtl/y86_reg_file.sv
// rtl/y86_reg_file.sv - Y86-64 decode/write-back register file, two read, two write ports
module y86_reg_file
  import y86_pkg::*;
#(
  parameter int                 DATA_W    = y86_pkg::DATA_W,
  parameter int                 NUM_REGS  = y86_pkg::NUM_REGS,
  parameter logic [DATA_W-1:0]  RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic              wr_en,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic              wr_conflict
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              same_dst;

  assign same_dst = (dst_e == dst_m) && is_real_id(dst_e);

  // M checked before E so popq %rsp keeps the loaded value on a collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (reg_id_t'(i) == RSP) ? RSP_RESET : '0;
      end
      wr_conflict <= 1'b0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dst_m == reg_id_t'(i)) begin
          regs[i] <= val_m;
        end else if (dst_e == reg_id_t'(i)) begin
          regs[i] <= val_e;
        end
      end
      wr_conflict <= same_dst;
    end
  end

  y86_reg_read_mux #(.W(DATA_W), .NREGS(NUM_REGS)) u_mux_a (
    .regs (regs),
    .sel  (src_a),
    .val  (val_a)
  );

  y86_reg_read_mux #(.W(DATA_W), .NREGS(NUM_REGS)) u_mux_b (
    .regs (regs),
    .sel  (src_b),
    .val  (val_b)
  );

  y86_reg_read_mux #(.W(DATA_W), .NREGS(NUM_REGS)) u_mux_dbg (
    .regs (regs),
    .sel  (dbg_sel),
    .val  (dbg_val)
  );

endmodule

// File: tb/tb_y86_reg_file.sv
// tb/tb_y86_reg_file.sv - vector table, corner sequences and random model check for y86_reg_file
module tb_y86_reg_file;

  localparam logic [63:0] RSP_R = 64'h0000_7FFF_F000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_a, src_b, dst_e, dst_m, dbg_sel;
  logic [63:0] val_a, val_b, val_e, val_m, dbg_val;
  logic        wr_en, wr_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  y86_reg_file #(.DATA_W(64), .NUM_REGS(15), .RSP_RESET(RSP_R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_a       (src_a),
    .src_b       (src_b),
    .val_a       (val_a),
    .val_b       (val_b),
    .dst_e       (dst_e),
    .val_e       (val_e),
    .dst_m       (dst_m),
    .val_m       (val_m),
    .wr_en       (wr_en),
    .dbg_sel     (dbg_sel),
    .dbg_val     (dbg_val),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    logic [3:0]  sa;
    logic [63:0] ea;
    logic [3:0]  sb;
    logic [63:0] eb;
    logic        ec;
  } vec_t;

  vec_t vt [10];

  logic [63:0] mdl [15];
  logic        mconf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mread(input logic [3:0] id);
    return (id == 4'hF) ? 64'h0 : mdl[id];
  endfunction

  function automatic logic [3:0] rand_id();
    int r;
    r = $urandom_range(0, 18);
    return (r > 14) ? 4'hF : 4'(r);
  endfunction

  initial begin
    vt[0] = '{1'b1, 4'h3, 64'hDEAD_BEEF_0000_0001, 4'hF, 64'h0, 4'h3, 64'hDEAD_BEEF_0000_0001, 4'h4, RSP_R, 1'b0};
    vt[1] = '{1'b1, 4'h1, 64'h5, 4'h2, 64'h7, 4'h1, 64'h5, 4'h2, 64'h7, 1'b0};
    vt[2] = '{1'b1, 4'h4, 64'h100, 4'h4, 64'h200, 4'h4, 64'h200, 4'h3, 64'hDEAD_BEEF_0000_0001, 1'b1};
    vt[3] = '{1'b1, 4'h6, 64'h11, 4'hF, 64'h99, 4'h6, 64'h11, 4'h4, 64'h200, 1'b0};
    vt[4] = '{1'b1, 4'h8, 64'h8, 4'h8, 64'h88, 4'h8, 64'h88, 4'h6, 64'h11, 1'b1};
    vt[5] = '{1'b0, 4'h5, 64'h9, 4'h5, 64'h3, 4'h5, 64'h0, 4'h8, 64'h88, 1'b1};
    vt[6] = '{1'b1, 4'hF, 64'h77, 4'hF, 64'h66, 4'h1, 64'h5, 4'h2, 64'h7, 1'b0};
    vt[7] = '{1'b1, 4'hF, 64'h0, 4'h9, 64'hABC, 4'h9, 64'hABC, 4'hF, 64'h0, 1'b0};
    vt[8] = '{1'b1, 4'hE, 64'h8000_0000_0000_0000, 4'h0, 64'hFFFF_FFFF_FFFF_FFFE,
              4'hE, 64'h8000_0000_0000_0000, 4'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vt[9] = '{1'b1, 4'hF, 64'h1, 4'hF, 64'h2, 4'hF, 64'h0, 4'hE, 64'h8000_0000_0000_0000, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0;
    src_a = 4'hF; src_b = 4'hF; dbg_sel = 4'h0;
    dst_e = 4'hF; dst_m = 4'hF; val_e = '0; val_m = '0;
    #2;
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("reset_reg%0d", i), dbg_val, (i == 4) ? RSP_R : 64'h0);
    end
    check("reset_conflict", {63'h0, wr_conflict}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      wr_en = vt[i].we; dst_e = vt[i].de; val_e = vt[i].ve;
      dst_m = vt[i].dm; val_m = vt[i].vm;
      step();
      wr_en = 1'b0;
      src_a = vt[i].sa; src_b = vt[i].sb; dbg_sel = vt[i].sa;
      #1;
      check($sformatf("vec%0d_val_a", i), val_a, vt[i].ea);
      check($sformatf("vec%0d_val_b", i), val_b, vt[i].eb);
      check($sformatf("vec%0d_dbg", i), dbg_val, vt[i].ea);
      check($sformatf("vec%0d_conflict", i), {63'h0, wr_conflict}, {63'h0, vt[i].ec});
    end

    // async reset between edges, with a conflict pending to be cleared
    wr_en = 1'b1; dst_e = 4'h7; val_e = 64'h1; dst_m = 4'h7; val_m = '1;
    step();
    wr_en = 1'b0; dbg_sel = 4'h7; src_a = 4'h4;
    #1;
    check("pre_rst_reg7", dbg_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("pre_rst_conflict", {63'h0, wr_conflict}, 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_reg7", dbg_val, 64'h0);
    check("async_rst_rsp", val_a, RSP_R);
    check("async_rst_conflict", {63'h0, wr_conflict}, 64'h0);
    wr_en = 1'b1; dst_e = 4'h3; val_e = 64'h5; dst_m = 4'hF;
    step();
    dbg_sel = 4'h3;
    #1;
    check("write_in_reset_ignored", dbg_val, 64'h0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // no bypass: a pending write is invisible until its edge
    wr_en = 1'b1; dst_e = 4'h3; val_e = 64'h1234; dst_m = 4'hF; src_a = 4'h3;
    #1;
    check("no_bypass_old", val_a, 64'h0);
    step();
    check("no_bypass_new", val_a, 64'h1234);

    for (int i = 0; i < 15; i++) mdl[i] = 64'h0;
    mdl[4] = RSP_R;
    mdl[3] = 64'h1234;
    mconf  = 1'b0;

    for (int it = 0; it < 400; it++) begin
      wr_en = ($urandom_range(0, 3) != 0);
      dst_e = rand_id(); dst_m = rand_id();
      if ($urandom_range(0, 7) == 0) dst_m = dst_e;
      val_e = {$urandom, $urandom}; val_m = {$urandom, $urandom};
      src_a = rand_id(); src_b = rand_id(); dbg_sel = rand_id();
      #1;
      check("rnd_pre_val_a", val_a, mread(src_a));
      step();
      if (wr_en) begin
        if (dst_e != 4'hF) mdl[dst_e] = val_e;
        if (dst_m != 4'hF) mdl[dst_m] = val_m;
        mconf = (dst_e == dst_m) && (dst_e != 4'hF);
      end
      check("rnd_val_a", val_a, mread(src_a));
      check("rnd_val_b", val_b, mread(src_b));
      check("rnd_dbg", dbg_val, mread(dbg_sel));
      check("rnd_conflict", {63'h0, wr_conflict}, {63'h0, mconf});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
